// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath channel-group blocks.
//
// Contents:
//   state_t      - serializer FSM encoding (IDLE=0, SEND=1)
//   ch_width()   - width of channel index / count fields for a given IN_CH
//   group_offset - bit offset of channel group c inside a packed frame
package conv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // One extra bit beyond $clog2 so that a count equal to IN_CH fits.
    function automatic int ch_width(input int in_ch);
        return $clog2(in_ch) + 1;
    endfunction

    function automatic int group_offset(input int c, input int out_num, input int width);
        return c * out_num * width;
    endfunction

endpackage

// File: rtl/ch_slice_mux.sv
// Combinational channel-group selector: picks group i_ch out of a packed
// frame of IN_CH groups, each OUT_NUM*WIDTH bits wide.
//
// Ports:
//   i_frame  in   IN_CH*OUT_NUM*WIDTH  packed frame, group c at c*OUT_NUM*WIDTH
//   i_ch     in   CH_W                 group index
//   o_group  out  OUT_NUM*WIDTH        selected group (zero if i_ch >= IN_CH)
module ch_slice_mux
    import conv_pkg::*;
#(
    parameter int WIDTH   = 30,
    parameter int IN_CH   = 3,
    parameter int OUT_NUM = 2,
    parameter int CH_W    = 3
) (
    input  logic [IN_CH*OUT_NUM*WIDTH-1:0] i_frame,
    input  logic [CH_W-1:0]                i_ch,
    output logic [OUT_NUM*WIDTH-1:0]       o_group
);

    localparam int GW = OUT_NUM * WIDTH;

    logic [GW-1:0] w_groups [IN_CH];

    generate
        for (genvar gi = 0; gi < IN_CH; gi++) begin : g_split
            assign w_groups[gi] = i_frame[group_offset(gi, OUT_NUM, WIDTH) +: GW];
        end
    endgenerate

    // Compare-and-select rather than a direct array index so that an index
    // wider than the group count never reads outside the array.
    always_comb begin
        o_group = '0;
        for (int c = 0; c < IN_CH; c++) begin
            if (i_ch == CH_W'(c)) begin
                o_group = w_groups[c];
            end
        end
    end

endmodule

// File: rtl/channel_group_serializer.sv
// Registered, handshaked channel-group serializer. Captures one packed frame
// of IN_CH groups and streams a window of them, one group per beat, starting
// at a chosen group and wrapping modulo IN_CH.
//
// Ports:
//   i_clk       in   1                    clock, rising edge
//   i_rst       in   1                    synchronous active-high reset
//   i_valid     in   1                    input frame valid
//   o_ready     out  1                    frame can be accepted this cycle
//   i_data      in   IN_CH*OUT_NUM*WIDTH  packed input frame
//   i_ch_first  in   CH_W                 first group (>= IN_CH means 0)
//   i_ch_num    in   CH_W                 groups to emit (0 or > IN_CH means IN_CH)
//   o_valid     out  1                    output beat valid
//   i_ready     in   1                    downstream accepts beat
//   o_data      out  OUT_NUM*WIDTH        current group
//   o_ch        out  CH_W                 index of the current group
//   o_last      out  1                    final beat of the frame
module channel_group_serializer
    import conv_pkg::*;
#(
    parameter  int WIDTH   = 30,
    parameter  int IN_CH   = 3,
    parameter  int OUT_NUM = 2,
    localparam int CH_W    = ch_width(IN_CH)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [IN_CH*OUT_NUM*WIDTH-1:0] i_data,
    input  logic [CH_W-1:0]                i_ch_first,
    input  logic [CH_W-1:0]                i_ch_num,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [OUT_NUM*WIDTH-1:0]       o_data,
    output logic [CH_W-1:0]                o_ch,
    output logic                           o_last
);

    localparam int FW = IN_CH * OUT_NUM * WIDTH;
    localparam logic [CH_W-1:0] FULL_CNT = CH_W'(IN_CH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(IN_CH - 1);
    localparam logic [CH_W-1:0] ONE      = CH_W'(1);

    state_t          r_state;
    state_t          w_state_next;
    logic [FW-1:0]   r_buf;
    logic [CH_W-1:0] r_ch;
    logic [CH_W-1:0] r_rem;
    logic [CH_W-1:0] w_ch_next;
    logic [CH_W-1:0] w_rem_next;
    logic            w_valid;
    logic            w_last;
    logic            w_beat;
    logic            w_ready;
    logic            w_load;

    always_comb begin
        w_valid      = (r_state == SEND);
        w_last       = w_valid && (r_rem == ONE);
        w_beat       = w_valid && i_ready;
        // Accepting a new frame while the last beat leaves lets frames
        // stream back-to-back with no bubble.
        w_ready      = (r_state == IDLE) || (w_beat && w_last);
        w_load       = i_valid && w_ready;

        w_state_next = r_state;
        w_ch_next    = r_ch;
        w_rem_next   = r_rem;

        if (w_beat) begin
            w_ch_next  = (r_ch == LAST_CH) ? '0 : r_ch + ONE;
            w_rem_next = r_rem - ONE;
            if (w_last) begin
                w_state_next = IDLE;
            end
        end

        // A load can only coincide with the final beat, so it overrides the
        // beat's counter updates and keeps the FSM in SEND.
        if (w_load) begin
            w_ch_next    = (i_ch_first >= FULL_CNT) ? '0 : i_ch_first;
            w_rem_next   = (i_ch_num == '0 || i_ch_num > FULL_CNT) ? FULL_CNT : i_ch_num;
            w_state_next = SEND;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_rem   <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ch    <= w_ch_next;
            r_rem   <= w_rem_next;
            if (w_load) begin
                r_buf <= i_data;
            end
        end
    end

    ch_slice_mux #(
        .WIDTH   (WIDTH),
        .IN_CH   (IN_CH),
        .OUT_NUM (OUT_NUM),
        .CH_W    (CH_W)
    ) u_ch_slice_mux (
        .i_frame (r_buf),
        .i_ch    (r_ch),
        .o_group (o_data)
    );

    assign o_valid = w_valid;
    assign o_ready = w_ready;
    assign o_ch    = r_ch;
    assign o_last  = w_last;

endmodule

// File: tb/tb_channel_group_serializer.sv
// Self-checking bench for channel_group_serializer: a directed vector table
// covering reset, wrap, back-pressure, back-to-back, illegal fields and
// mid-frame reset, followed by randomized traffic against a queue model.
module tb_channel_group_serializer;

    localparam int WIDTH   = 30;
    localparam int IN_CH   = 3;
    localparam int OUT_NUM = 2;
    localparam int CH_W    = $clog2(IN_CH) + 1;
    localparam int GW      = OUT_NUM * WIDTH;
    localparam int FW      = IN_CH * GW;

    logic            clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [FW-1:0]   i_data = '0;
    logic [CH_W-1:0] i_ch_first = '0;
    logic [CH_W-1:0] i_ch_num = '0;
    logic            o_valid;
    logic            i_ready = 1'b1;
    logic [GW-1:0]   o_data;
    logic [CH_W-1:0] o_ch;
    logic            o_last;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    channel_group_serializer #(
        .WIDTH   (WIDTH),
        .IN_CH   (IN_CH),
        .OUT_NUM (OUT_NUM)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .i_ch_first (i_ch_first),
        .i_ch_num   (i_ch_num),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_ch       (o_ch),
        .o_last     (o_last)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Distinct 60-bit pattern for group c of directed frame f.
    function automatic logic [GW-1:0] pat(input int f, input int c);
        logic [29:0] hi;
        logic [29:0] lo;
        hi = 30'(32'h1000_0000 + f * 16 + c);
        lo = 30'(32'h0ABC_0000 ^ (f * 256 + c * 3 + 7));
        return {hi, lo};
    endfunction

    function automatic logic [FW-1:0] frame_of(input int f);
        logic [FW-1:0] r;
        r = '0;
        for (int c = 0; c < IN_CH; c++) r[c*GW +: GW] = pat(f, c);
        return r;
    endfunction

    // Drive one cycle's inputs mid-cycle and let combinational paths settle.
    task automatic apply(input bit rst, input bit v, input logic [FW-1:0] d,
                         input int first, input int num, input bit rdy);
        @(negedge clk);
        i_rst      = rst;
        i_valid    = v;
        i_data     = d;
        i_ch_first = CH_W'(first);
        i_ch_num   = CH_W'(num);
        i_ready    = rdy;
        #1;
    endtask

    // ---------------- directed vector table ----------------
    // e_g: group index of expected o_data, 3 = expect all-zero data and ch 0,
    // -1 = data/ch not checked.
    typedef struct {
        bit rst; bit v; int fs; int first; int num; bit rdy; bit chk;
        bit e_v; bit e_r; int e_ch; bit e_l; int e_f; int e_g;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit rst, input bit v, input int fs, input int first,
                                input int num, input bit rdy, input bit chk, input bit e_v,
                                input bit e_r, input int e_ch, input bit e_l, input int e_f,
                                input int e_g);
        vec_t t;
        t.rst = rst; t.v = v; t.fs = fs; t.first = first; t.num = num; t.rdy = rdy;
        t.chk = chk; t.e_v = e_v; t.e_r = e_r; t.e_ch = e_ch; t.e_l = e_l;
        t.e_f = e_f; t.e_g = e_g;
        return t;
    endfunction

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [GW-1:0] data;
        int            ch;
        bit            last;
    } beat_t;

    beat_t mq[$];

    // Expand a frame into its beat list using modular arithmetic.
    task automatic model_load(input logic [FW-1:0] d, input int first, input int num);
        int f0;
        int n;
        beat_t b;
        f0 = (first >= IN_CH) ? 0 : first;
        n  = (num == 0 || num > IN_CH) ? IN_CH : num;
        for (int k = 0; k < n; k++) begin
            b.ch   = (f0 + k) % IN_CH;
            b.data = d[b.ch*GW +: GW];
            b.last = (k == n - 1);
            mq.push_back(b);
        end
    endtask

    initial begin
        // Reset and idle
        tbl.push_back(mk(1,0,0,0,0,1, 0, 0,1,0,0,0,3));
        tbl.push_back(mk(1,0,0,0,0,1, 1, 0,1,0,0,0,3));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 0,1,0,0,0,3));
        // Full frame with wrap: first=1 num=0
        tbl.push_back(mk(0,1,0,1,0,1, 1, 0,1,0,0,0,3));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 1,0,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 1,0,2,0,0,2));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 1,1,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 0,1,0,0,0,-1));
        // Back-pressure: first=0 num=2, ready low 3 cycles
        tbl.push_back(mk(0,1,0,0,2,0, 1, 0,1,0,0,0,-1));
        tbl.push_back(mk(0,0,0,0,0,0, 1, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 1, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 1, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 1,1,1,1,0,1));
        // Back-to-back: A (first=2 num=1) then B loaded on A's last beat
        tbl.push_back(mk(0,1,0,2,1,1, 1, 0,1,0,0,0,-1));
        tbl.push_back(mk(0,1,1,0,2,1, 1, 1,1,2,1,0,2));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 1,0,0,0,1,0));
        tbl.push_back(mk(0,1,0,0,0,0, 1, 1,0,1,1,1,1));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 1,1,1,1,1,1));
        // Illegal fields: first=3 num=3
        tbl.push_back(mk(0,1,0,3,3,1, 1, 0,1,0,0,0,-1));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 1,0,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 1,1,2,1,0,2));
        // num=0 means all groups
        tbl.push_back(mk(0,1,1,0,0,1, 1, 0,1,0,0,0,-1));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 1,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 1,0,1,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 1,1,2,1,1,2));
        // Reset after the first beat of a 3-beat frame
        tbl.push_back(mk(0,1,0,0,3,1, 1, 0,1,0,0,0,-1));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,1, 1, 1,0,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 0,1,0,0,0,3));
        tbl.push_back(mk(0,0,0,0,0,1, 1, 0,1,0,0,0,3));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].v, frame_of(tbl[i].fs), tbl[i].first, tbl[i].num, tbl[i].rdy);
            if (tbl[i].chk) begin
                check($sformatf("row%0d_valid", i), 64'(o_valid), 64'(tbl[i].e_v));
                check($sformatf("row%0d_ready", i), 64'(o_ready), 64'(tbl[i].e_r));
                check($sformatf("row%0d_last", i), 64'(o_last), 64'(tbl[i].e_l));
                if (tbl[i].e_g == 3) begin
                    check($sformatf("row%0d_data", i), 64'(o_data), 64'(0));
                    check($sformatf("row%0d_ch", i), 64'(o_ch), 64'(0));
                end else if (tbl[i].e_g >= 0) begin
                    check($sformatf("row%0d_data", i), 64'(o_data), 64'(pat(tbl[i].e_f, tbl[i].e_g)));
                    check($sformatf("row%0d_ch", i), 64'(o_ch), 64'(tbl[i].e_ch));
                end
            end
            $display("row %0d: rst=%0b valid=%0b ready_in=%0b -> o_valid=%0b o_ready=%0b o_ch=%0d o_last=%0b",
                     i, tbl[i].rst, tbl[i].v, tbl[i].rdy, o_valid, o_ready, o_ch, o_last);
            @(posedge clk);
        end

        // ---------------- randomized traffic ----------------
        mq.delete();
        for (int n = 0; n < 2000; n++) begin
            bit            rst;
            bit            v;
            bit            rdy;
            int            first;
            int            num;
            logic [FW-1:0] d;
            bit            e_valid;
            bit            e_ready;

            rst   = (n < 2) || ($urandom_range(0, 99) == 0);
            v     = ($urandom_range(0, 9) < 6);
            rdy   = ($urandom_range(0, 9) < 7);
            first = $urandom_range(0, 7);
            num   = $urandom_range(0, 7);
            for (int k = 0; k < FW / 30; k++) d[k*30 +: 30] = 30'($urandom);

            apply(rst, v, d, first, num, rdy);
            e_valid = (mq.size() != 0);
            e_ready = (mq.size() == 0) || (mq.size() == 1 && rdy);
            check("rand_valid", 64'(o_valid), 64'(e_valid));
            check("rand_ready", 64'(o_ready), 64'(e_ready));
            if (e_valid) begin
                check("rand_data", 64'(o_data), 64'(mq[0].data));
                check("rand_ch", 64'(o_ch), 64'(mq[0].ch));
                check("rand_last", 64'(o_last), 64'(mq[0].last));
            end else begin
                check("rand_last_idle", 64'(o_last), 64'(0));
            end
            @(posedge clk);
            if (rst) begin
                mq.delete();
            end else begin
                if (e_valid && rdy) void'(mq.pop_front());
                if (v && e_ready) begin
                    model_load(d, first, num);
                    $display("rand cycle %0d: frame loaded first=%0d num=%0d beats=%0d",
                             n, first, num, mq.size());
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/channel_group_serializer.md
# channel_group_serializer

Registered, handshaked successor to the combinational channel-group selector in the convolution datapath. It captures one packed frame of IN_CH channel groups, each OUT_NUM×WIDTH bits, and streams a run-time window of those groups one per beat, starting at a chosen channel and wrapping modulo IN_CH. It sits between the parallel MAC array output and the narrower accumulation/write-back stage, with valid/ready on both sides.

## Interface
- WIDTH, 30: bits per output element.
- IN_CH, 3: channel groups per input frame.
- OUT_NUM, 2: elements per channel group (per output beat).
- CH_W (localparam), $clog2(IN_CH)+1: width of channel index/count fields.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input frame valid.
- o_ready  out  1  block can accept a frame this cycle.
- i_data  in  IN_CH*OUT_NUM*WIDTH  packed frame; group c at bits [c*OUT_NUM*WIDTH +: OUT_NUM*WIDTH].
- i_ch_first  in  CH_W  first group to emit; sampled with the frame.
- i_ch_num  in  CH_W  groups to emit; 0 means IN_CH; sampled with the frame.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts beat.
- o_data  out  OUT_NUM*WIDTH  current group.
- o_ch  out  CH_W  index of the group on o_data.
- o_last  out  1  final beat of the frame.

## Operation
- States: IDLE, SEND. Reset enters IDLE.
- Load fires on i_valid && o_ready. It captures i_data into the frame buffer and sets ch = i_ch_first. If i_ch_first ≥ IN_CH, ch = 0. It sets rem = (i_ch_num == 0 || i_ch_num > IN_CH) ? IN_CH : i_ch_num. State becomes SEND.
- o_ready = (state == IDLE) || (o_valid && i_ready && o_last).
- SEND: o_valid = 1, o_data = buffer group ch, o_ch = ch, o_last = (rem == 1).
- Beat fires on o_valid && i_ready:
  - ch advances: ch = (ch == IN_CH-1) ? 0 : ch+1.
  - rem decrements by 1.
  - When the fired beat has o_last = 1, the next state is IDLE, unless a load fires in the same cycle. In that case the state stays SEND with the new frame.
- Back-pressure: while o_valid && !i_ready, o_data, o_ch and o_last hold unchanged.
- i_data may change freely after the load cycle; the buffer is the only source for o_data.
- The window may emit a group at most once per frame, since rem ≤ IN_CH.

## Timing
- Reset values: o_valid=0, o_last=0, o_ch=0, o_data=0 (buffer cleared), o_ready=1.
- Load latency: a load in cycle N gives o_valid=1 with the first group in cycle N+1.
- Throughput: one beat per cycle with i_ready held high. Frames of k groups issue back-to-back every k cycles, because a new load overlaps the last beat.
- o_ready is combinational from i_ready in the last-beat cycle. No other output depends combinationally on inputs.
- Reset mid-frame: remaining beats are dropped, and the outputs return to reset values the next cycle.
- IN_CH=1: ch stays 0 and every frame is one beat with o_last=1.

## Structure
- Shared package conv_pkg holds:
  - state encoding (IDLE=0, SEND=1);
  - the CH_W expression;
  - the group-offset helper (c*OUT_NUM*WIDTH).
- One sub-module, ch_slice_mux. It is the parametrised combinational group selector (buffer, ch → o_data) and is instantiated once.
- The FSM, ch/rem counters and buffer live in channel_group_serializer.

## Test plan
All scenarios use WIDTH=30, IN_CH=3, OUT_NUM=2; G0/G1/G2 are distinct 60-bit patterns.
- Reset and idle: assert i_rst for 2 cycles, then release with i_valid=0. Expected: o_valid=0, o_ready=1, o_data=0, o_ch=0.
- Full frame, wrap: load with i_ch_first=1, i_ch_num=0 and i_ready=1. Expected beats on consecutive cycles: G1/ch1, G2/ch2, G0/ch0 with o_last on the third beat, then IDLE.
- Back-pressure: load with first=0, num=2, i_ready low for 3 cycles. Expected: G0/ch0 held stable for 3 cycles, then G1 with o_last=1.
- Back-to-back: frame A (num=1) then frame B presented while A's last beat fires. Expected: o_ready=1 in that cycle, B's first beat the next cycle, no o_valid gap.
- Illegal fields: i_ch_first=3, i_ch_num=3. Expected: ch starts at 0 and 3 beats are emitted. With i_ch_num=0, expected 3 beats.
- Reset mid-frame: i_rst pulses after the first beat of a 3-beat frame. Expected: next cycle o_valid=0, o_ready=1, and no further beats.
